pcpi_result_nibble_tx: RTL and testbench
========================================

Name: pcpi_result_nibble_tx

Overview:
Nibble-serial transmitter for returning 32-bit PCPI results (pcpi_rd) off-chip over the 4-bit pin budget. It is the return-direction counterpart of the nibble-serial instruction loader:
- Accepts one word through a valid/ready handshake.
- Sends it LSB-nibble-first, one nibble per send/ack exchange, with a mandatory idle gap between nibbles.
- Reports completion or an ack timeout.

It sits between the PCPI unit result path and the top-level uo_out pins.

Parameters:
- WORD_W, 32, transmitted word width; must be a multiple of 4.
- TIMEOUT, 255, maximum SEND cycles without ack before abort; 0 disables the timeout.
- TO_W, 8, timeout counter width; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  word offered.
- in_ready  out  1  block idle and able to accept a word.
- in_word  in  WORD_W  word to send; captured on the in_valid & in_ready cycle.
- nib_data  out  4  current nibble.
- nib_send  out  1  nibble valid; held until acked.
- nib_ack  in  1  receiver has latched nib_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse: last nibble acked.
- err  out  1  one-cycle pulse: ack timeout abort.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Outputs: all are registered (state-decoded from registers). No combinational path from any input to any output.
- Reset values: state=IDLE, in_ready=1, busy=0, nib_send=0, nib_data=0, done=0, err=0, idx=0, timeout counter=0.
- Reset mid-operation: takes effect at the next edge and abandons the word. nib_send=0 on the following cycle and no done/err pulse is produced.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch in_word into the shift register, idx=0, counter=0, go to SEND.
  - nib_ack is ignored.
- SEND:
  - nib_send=1; nib_data = word[4*idx+3:4*idx], stable for the whole state.
  - If nib_ack=1, go to GAP.
  - Else, if TIMEOUT≠0 and counter==TIMEOUT-1, go to IDLE with err=1 for that IDLE cycle.
  - Else counter++.
  - ack and timeout in the same cycle: ack wins.
- GAP:
  - Lasts exactly 1 cycle; nib_send=0 and nib_ack is ignored.
  - If idx==last: done=1 for this cycle, then IDLE.
  - Else idx++, counter=0, go to SEND.
- Nibble count: N = WORD_W/4 (8 at default).
- Nibble order: LSB nibble first.
- Busy handling: in_valid while busy is ignored; the word is not captured and not queued.
- Timing with the handshake at cycle 0 and nib_ack tied high:
  - Nibble k is in SEND at cycle 1+2k.
  - done is asserted at cycle 2N.
  - in_ready=1 at cycle 2N+1.
- Each SEND cycle without ack adds one cycle to that nibble.
- Back-to-back words: a new word may be accepted in the first IDLE cycle after done.

Optional Feature:
- Macro: NIBBLE_TX_CHECKSUM_EN.
- When defined:
  - A checksum nibble (XOR of all N data nibbles, computed at capture) is sent as nibble index N, after the data.
  - Total nibbles = N+1.
  - done follows the checksum GAP cycle (cycle 2N+2 at default timing).
  - The timeout applies to the checksum nibble as well.
- When undefined: exactly N nibbles are sent; no checksum logic is present.

Test Plan:
1. Reset, offer 0x89ABCDEF at cycle 0, ack tied 1 → nib_data F,E,D,C,B,A,9,8 at cycles 1,3,…,15; nib_send=0 at even cycles; done at cycle 16; in_ready=1 at cycle 17.
2. Word 0x00000005, ack raised 3 cycles after each nib_send rise → nib_send held high for 4 cycles per nibble with nib_data constant; exactly one GAP cycle between nibbles; 8 nibbles sent (5 then seven 0s); single done pulse.
3. TIMEOUT=4, ack held 0 → nib_send high cycles 1–4 with data nibble 0; err=1 at cycle 5 only; in_ready=1 at cycle 5; done never asserted.
4. rst asserted at cycle 6 during word 0x89ABCDEF → nib_send=0, busy=0, in_ready=1 the cycle after rst; next word 0x12345678 sends 8,7,6,5,4,3,2,1 starting with its own cycle 1.
5. While busy, pulse in_valid with 0xDEADBEEF → ignored; the original word completes unchanged and only one done pulse occurs.
6. NIBBLE_TX_CHECKSUM_EN defined, word 0x12345678, ack tied 1 → nibbles 8,7,6,5,4,3,2,1 followed by checksum 8 at cycle 17; done at cycle 18.

Source files
------------

// File: rtl/pcpi_result_nibble_tx.sv
// Nibble-serial transmitter for 32-bit PCPI results: valid/ready word in, LSB nibble first out
// over a send/ack exchange with a one-cycle gap. Optional checksum nibble: NIBBLE_TX_CHECKSUM_EN.
module pcpi_result_nibble_tx #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic [3:0]        nib_data,
    output logic              nib_send,
    input  logic              nib_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int N = WORD_W / 4;
`ifdef NIBBLE_TX_CHECKSUM_EN
    localparam int NTOT = N + 1;
    localparam int SH_W = WORD_W + 4;
`else
    localparam int NTOT = N;
    localparam int SH_W = WORD_W;
`endif
    localparam int IDX_W = (NTOT > 1) ? $clog2(NTOT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTOT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SH_W-1:0]  r_shift;
    logic [IDX_W-1:0] r_idx;
    logic [TO_W-1:0]  r_cnt;
    logic             r_err;
    logic             w_accept;
    logic             w_abort;
    logic             w_adv;
    logic             w_to_hit;
    logic [SH_W-1:0]  w_load;

`ifdef NIBBLE_TX_CHECKSUM_EN
    function automatic logic [3:0] f_xor_nibbles(input logic [WORD_W-1:0] w);
        logic [3:0] acc;
        acc = 4'h0;
        for (int i = 0; i < N; i++) begin
            acc = acc ^ w[4*i +: 4];
        end
        return acc;
    endfunction

    assign w_load = {f_xor_nibbles(in_word), in_word};
`else
    assign w_load = in_word;
`endif

    // Timeout compare; a zero TIMEOUT removes the abort path entirely.
    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign w_to_hit = 1'b0;
        end else begin : g_timeout
            assign w_to_hit = (r_cnt == TO_W'(TIMEOUT - 1));
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; ack takes priority over a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SEND;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SEND: begin
                if (nib_ack) begin
                    w_state_nxt = S_GAP;
                end else if (w_to_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
            S_GAP: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_adv       = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Shift register, nibble index, ack-wait counter and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_abort;
            if (w_accept) begin
                r_shift <= w_load;
                r_idx   <= '0;
                r_cnt   <= '0;
            end else if (w_adv) begin
                r_shift <= {4'h0, r_shift[SH_W-1:4]};
                r_idx   <= r_idx + IDX_W'(1);
                r_cnt   <= '0;
            end else if ((r_state == S_SEND) && !nib_ack && !w_to_hit) begin
                r_cnt <= r_cnt + TO_W'(1);
            end
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign nib_send = (r_state == S_SEND);
    assign nib_data = r_shift[3:0];
    assign done     = (r_state == S_GAP) && (r_idx == LAST_IDX);
    assign err      = r_err;

endmodule

// File: tb/tb_pcpi_result_nibble_tx.sv
// Self-checking bench for pcpi_result_nibble_tx; expected nibble streams come from word arithmetic.
module tb_pcpi_result_nibble_tx;

    localparam int WORD_W  = 32;
    localparam int N       = WORD_W / 4;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic [3:0]  nib_data;
    logic        nib_send;
    logic        nib_ack;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pcpi_result_nibble_tx #(
        .WORD_W (WORD_W),
        .TIMEOUT(TIMEOUT),
        .TO_W   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_word (in_word),
        .nib_data(nib_data),
        .nib_send(nib_send),
        .nib_ack (nib_ack),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stream: nibble k = (w >> 4k) mod 16, plus XOR of all nibbles when checksum is built in.
    task automatic send_word(input logic [31:0] w, input int mode, input int inj);
        logic [3:0] q[$];
        logic [3:0] cs;
        int         cyc;
        int         d;
        cs = 4'h0;
        for (int k = 0; k < N; k++) begin
            q.push_back(4'((w >> (4 * k)) % 16));
            cs = cs ^ 4'((w >> (4 * k)) % 16);
        end
`ifdef NIBBLE_TX_CHECKSUM_EN
        q.push_back(cs);
`endif
        chk("start_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_word  = w;
        nib_ack  = 1'($urandom_range(0, 1));
        tick();
        in_valid = 1'b0;
        in_word  = $urandom;
        cyc      = 1;
        foreach (q[k]) begin
            d = (mode == 0) ? 0 : (mode == 1) ? 3 : int'($urandom_range(0, 3));
            for (int c = 0; c <= d; c++) begin
                in_valid = (cyc == inj);
                if (cyc == inj) in_word = 32'hDEADBEEF;
                nib_ack = (c == d);
                chk("send",  32'(nib_send), 32'd1);
                chk("data",  32'(nib_data), 32'(q[k]));
                chk("busy",  32'(busy),     32'd1);
                chk("ready", 32'(in_ready), 32'd0);
                chk("done",  32'(done),     32'd0);
                chk("err",   32'(err),      32'd0);
                tick();
                cyc++;
            end
            in_valid = (cyc == inj);
            nib_ack  = 1'($urandom_range(0, 1));
            chk("gap_send", 32'(nib_send), 32'd0);
            chk("gap_done", 32'(done), 32'(k == q.size() - 1));
            chk("gap_busy", 32'(busy), 32'd1);
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        nib_ack  = 1'b0;
        chk("end_ready", 32'(in_ready), 32'd1);
        chk("end_busy",  32'(busy),     32'd0);
        chk("end_done",  32'(done),     32'd0);
        chk("end_send",  32'(nib_send), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_word  = 32'h0;
        nib_ack  = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_send",  32'(nib_send), 32'd0);
        chk("rst_data",  32'(nib_data), 32'd0);
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_err",   32'(err),      32'd0);
        rst = 1'b0;
        tick();

        // Ack tied high, then ack three cycles late (ack coincides with the last pre-timeout cycle).
        send_word(32'h89ABCDEF, 0, -1);
        send_word(32'h00000005, 1, -1);

        // Ack never comes: abort after TIMEOUT send cycles.
        w        = $urandom;
        in_valid = 1'b1;
        in_word  = w;
        tick();
        in_valid = 1'b0;
        nib_ack  = 1'b0;
        for (int c = 0; c < TIMEOUT; c++) begin
            chk("to_send", 32'(nib_send), 32'd1);
            chk("to_data", 32'(nib_data), 32'(w % 16));
            chk("to_err",  32'(err),      32'd0);
            chk("to_done", 32'(done),     32'd0);
            tick();
        end
        chk("to_err_pulse", 32'(err),      32'd1);
        chk("to_ready",     32'(in_ready), 32'd1);
        chk("to_busy",      32'(busy),     32'd0);
        chk("to_send_off",  32'(nib_send), 32'd0);
        chk("to_done_off",  32'(done),     32'd0);
        tick();
        chk("to_err_clear", 32'(err), 32'd0);

        // Reset in the middle of a word.
        in_valid = 1'b1;
        in_word  = 32'h89ABCDEF;
        tick();
        in_valid = 1'b0;
        nib_ack  = 1'b1;
        for (int c = 1; c < 6; c++) begin
            if (c == 5) chk("mid_data", 32'(nib_data), 32'hD);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nib_ack = 1'b0;
        chk("mid_rst_send",  32'(nib_send), 32'd0);
        chk("mid_rst_busy",  32'(busy),     32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_done",  32'(done),     32'd0);
        chk("mid_rst_err",   32'(err),      32'd0);
        send_word(32'h12345678, 0, -1);

        // A word offered while busy is dropped.
        send_word($urandom, 2, 4);

        for (int i = 0; i < 10; i++) begin
            send_word($urandom, 2, -1);
        end
        send_word(32'h12345678, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
